// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes and FSM state type for the MEM-stage LSU
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, RSP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication, load extract/extend
// Misaligned detect active only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_LENGTH = 32
) (
   input  logic [2:0]             i_funct3,
   input  logic                   i_is_load,
   input  logic [1:0]             i_addr_lo,
   input  logic [DATA_LENGTH-1:0] i_w_data,
   input  logic [DATA_LENGTH-1:0] i_rdata,
   output logic [3:0]             o_be,
   output logic [DATA_LENGTH-1:0] o_wdata,
   output logic [DATA_LENGTH-1:0] o_load_data,
   output logic                   o_misaligned
);
   logic        w_is_byte;
   logic        w_is_half;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_is_byte = (i_funct3 == F3_B) || (i_funct3 == F3_BU);
   assign w_is_half = (i_funct3 == F3_H) || (i_funct3 == F3_HU);

   always_comb begin
      w_byte      = i_rdata[7:0];
      w_half      = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_be        = 4'b1111;
      o_wdata     = i_w_data;
      o_load_data = i_rdata;
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // Undefined funct3 codes fall through to word behaviour
      if (w_is_byte) begin
         o_be        = 4'b0001 << i_addr_lo;
         o_wdata     = {4{i_w_data[7:0]}};
         o_load_data = (i_funct3 == F3_BU) ? {{(DATA_LENGTH-8){1'b0}}, w_byte}
                                           : {{(DATA_LENGTH-8){w_byte[7]}}, w_byte};
      end else if (w_is_half) begin
         o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         o_wdata     = {2{i_w_data[15:0]}};
         o_load_data = (i_funct3 == F3_HU) ? {{(DATA_LENGTH-16){1'b0}}, w_half}
                                           : {{(DATA_LENGTH-16){w_half[15]}}, w_half};
      end
      if (i_is_load) o_be = 4'b1111;
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign o_misaligned = (w_is_half && i_addr_lo[0]) ||
                         (!w_is_byte && !w_is_half && (i_addr_lo != 2'b00));
`else
   assign o_misaligned = 1'b0;
`endif
endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with valid/gnt/rvalid data port
// Optional misaligned-access trap selected by LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int DATA_LENGTH = 32,
   parameter int PC_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_in,
   input  logic                   mem_read_in,
   input  logic                   mem_write_in,
   input  logic [2:0]             funct3_in,
   input  logic [DATA_LENGTH-1:0] alu_res_in,
   input  logic [DATA_LENGTH-1:0] w_data_in,
   input  logic [4:0]             rd_in,
   input  logic [PC_WIDTH-1:0]    pc_plus4_in,
   output logic                   stall_out,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [DATA_LENGTH-1:0] dmem_addr,
   output logic [3:0]             dmem_be,
   output logic [DATA_LENGTH-1:0] dmem_wdata,
   input  logic                   dmem_gnt,
   input  logic                   dmem_rvalid,
   input  logic [DATA_LENGTH-1:0] dmem_rdata,
   output logic                   valid_out,
   output logic [DATA_LENGTH-1:0] result_out,
   output logic [4:0]             rd_out,
   output logic [PC_WIDTH-1:0]    pc_plus4_out,
   output logic                   misaligned_out
);
   lsu_state_t r_state, w_state_nxt;

   logic                   r_is_load;
   logic [2:0]             r_funct3;
   logic [DATA_LENGTH-1:0] r_addr;
   logic [DATA_LENGTH-1:0] r_w_data;
   logic [4:0]             r_rd;
   logic [PC_WIDTH-1:0]    r_pc;

   logic                   w_idle;
   logic                   w_mem_op;
   logic                   w_capture;
   logic                   w_sel_is_load;
   logic [2:0]             w_sel_funct3;
   logic [DATA_LENGTH-1:0] w_sel_addr;
   logic [DATA_LENGTH-1:0] w_sel_w_data;
   logic [3:0]             w_be;
   logic [DATA_LENGTH-1:0] w_wdata;
   logic [DATA_LENGTH-1:0] w_load_data;
   logic                   w_misaligned;

   assign w_idle   = (r_state == IDLE);
   assign w_mem_op = valid_in && (mem_read_in || mem_write_in);

   // Entry cycle formats straight from EX/MEM; later cycles use the captured copy
   assign w_sel_is_load = w_idle ? mem_read_in : r_is_load;
   assign w_sel_funct3  = w_idle ? funct3_in   : r_funct3;
   assign w_sel_addr    = w_idle ? alu_res_in  : r_addr;
   assign w_sel_w_data  = w_idle ? w_data_in   : r_w_data;

   lsu_align #(.DATA_LENGTH(DATA_LENGTH)) u_align (
      .i_funct3     (w_sel_funct3),
      .i_is_load    (w_sel_is_load),
      .i_addr_lo    (w_sel_addr[1:0]),
      .i_w_data     (w_sel_w_data),
      .i_rdata      (dmem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data),
      .o_misaligned (w_misaligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_is_load <= 1'b0;
         r_funct3  <= '0;
         r_addr    <= '0;
         r_w_data  <= '0;
         r_rd      <= '0;
         r_pc      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_is_load <= mem_read_in;
            r_funct3  <= funct3_in;
            r_addr    <= alu_res_in;
            r_w_data  <= w_data_in;
            r_rd      <= rd_in;
            r_pc      <= pc_plus4_in;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_capture      = 1'b0;
      stall_out      = 1'b0;
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      dmem_addr      = '0;
      dmem_be        = '0;
      dmem_wdata     = '0;
      valid_out      = 1'b0;
      result_out     = '0;
      rd_out         = '0;
      pc_plus4_out   = '0;
      misaligned_out = 1'b0;
      case (r_state)
         IDLE: begin
            valid_out    = valid_in;
            result_out   = alu_res_in;
            rd_out       = rd_in;
            pc_plus4_out = pc_plus4_in;
            if (w_mem_op) begin
               if (w_misaligned) begin
                  misaligned_out = 1'b1;
               end else begin
                  w_capture  = 1'b1;
                  dmem_req   = 1'b1;
                  dmem_we    = !mem_read_in;
                  dmem_addr  = {alu_res_in[DATA_LENGTH-1:2], 2'b00};
                  dmem_be    = w_be;
                  dmem_wdata = w_wdata;
                  if (!(dmem_gnt && !mem_read_in)) begin
                     valid_out   = 1'b0;
                     stall_out   = 1'b1;
                     w_state_nxt = dmem_gnt ? RSP : REQ;
                  end
               end
            end
         end
         REQ: begin
            dmem_req     = 1'b1;
            dmem_we      = !r_is_load;
            dmem_addr    = {r_addr[DATA_LENGTH-1:2], 2'b00};
            dmem_be      = w_be;
            dmem_wdata   = w_wdata;
            rd_out       = r_rd;
            pc_plus4_out = r_pc;
            stall_out    = 1'b1;
            if (dmem_gnt) begin
               if (r_is_load) begin
                  w_state_nxt = RSP;
               end else begin
                  valid_out   = 1'b1;
                  result_out  = r_addr;
                  stall_out   = 1'b0;
                  w_state_nxt = IDLE;
               end
            end
         end
         RSP: begin
            rd_out       = r_rd;
            pc_plus4_out = r_pc;
            stall_out    = 1'b1;
            if (dmem_rvalid) begin
               valid_out   = 1'b1;
               result_out  = w_load_data;
               stall_out   = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (rst) begin
         stall_out      = 1'b0;
         dmem_req       = 1'b0;
         dmem_we        = 1'b0;
         dmem_addr      = '0;
         dmem_be        = '0;
         dmem_wdata     = '0;
         valid_out      = 1'b0;
         result_out     = '0;
         rd_out         = '0;
         pc_plus4_out   = '0;
         misaligned_out = 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, mem_read_in, mem_write_in;
   logic [2:0]  funct3_in;
   logic [31:0] alu_res_in, w_data_in;
   logic [4:0]  rd_in;
   logic [31:0] pc_plus4_in;
   logic        stall_out, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        valid_out;
   logic [31:0] result_out;
   logic [4:0]  rd_out;
   logic [31:0] pc_plus4_out;
   logic        misaligned_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.DATA_LENGTH(32), .PC_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .funct3_in(funct3_in), .alu_res_in(alu_res_in),
      .w_data_in(w_data_in), .rd_in(rd_in), .pc_plus4_in(pc_plus4_in),
      .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .valid_out(valid_out), .result_out(result_out), .rd_out(rd_out),
      .pc_plus4_out(pc_plus4_out), .misaligned_out(misaligned_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      valid_in = 0; mem_read_in = 0; mem_write_in = 0; funct3_in = 0;
      alu_res_in = 0; w_data_in = 0; rd_in = 0; pc_plus4_in = 0;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
   endtask

   task automatic op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
      valid_in = 1; mem_read_in = rd_en; mem_write_in = wr_en; funct3_in = f3;
      alu_res_in = addr; w_data_in = wd; rd_in = rd; pc_plus4_in = addr + 32'h100;
   endtask

   initial begin
      int  stalls;
      bit  done;
      rst = 1;
      quiet();
      step(); step();
      #1;
      check("rst_valid", {31'b0, valid_out}, 32'd0);
      check("rst_stall", {31'b0, stall_out}, 32'd0);
      rst = 0;
      step();
      check("idle_req", {31'b0, dmem_req}, 32'd0);
      check("idle_result", result_out, 32'h0);

      // Non-memory passthrough
      op(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
      #1;
      check("alu_valid", {31'b0, valid_out}, 32'd1);
      check("alu_result", result_out, 32'h0000_1234);
      check("alu_stall", {31'b0, stall_out}, 32'd0);
      check("alu_req", {31'b0, dmem_req}, 32'd0);
      check("alu_rd", {27'b0, rd_out}, 32'd5);
      step();

      // SB immediate grant
      op(0, 1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd0);
      dmem_gnt = 1;
      #1;
      check("sb_addr", dmem_addr, 32'h0000_1000);
      check("sb_be", {28'b0, dmem_be}, 32'h8);
      check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
      check("sb_we", {31'b0, dmem_we}, 32'd1);
      check("sb_valid", {31'b0, valid_out}, 32'd1);
      check("sb_stall", {31'b0, stall_out}, 32'd0);
      step();

      // SH at upper half
      op(0, 1, 3'b001, 32'h0000_1002, 32'hAABB_CCDD, 5'd0);
      #1;
      check("sh_be", {28'b0, dmem_be}, 32'hC);
      check("sh_wdata", dmem_wdata, 32'hCCDD_CCDD);
      step();

      // LB then LBU with one stall cycle
      for (int k = 0; k < 2; k++) begin
         op(1, 0, (k == 0) ? 3'b000 : 3'b100, 32'h0000_2001, 32'h0, 5'd9);
         dmem_gnt = 1;
         #1;
         check("lb_stall", {31'b0, stall_out}, 32'd1);
         check("lb_be", {28'b0, dmem_be}, 32'hF);
         check("lb_valid0", {31'b0, valid_out}, 32'd0);
         step();
         dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h1122_8044;
         #1;
         check("lb_req_rsp", {31'b0, dmem_req}, 32'd0);
         check("lb_valid", {31'b0, valid_out}, 32'd1);
         check("lb_stall1", {31'b0, stall_out}, 32'd0);
         check("lb_result", result_out, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         check("lb_rd", {27'b0, rd_out}, 32'd9);
         step();
         dmem_rvalid = 0;
      end

      // LH with grant delayed three cycles, response two cycles after grant
      op(1, 0, 3'b001, 32'h0000_2002, 32'h0, 5'd12);
      stalls = 0;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         dmem_gnt = (c == 3);
         dmem_rvalid = (c == 5);
         dmem_rdata = 32'h8001_0000;
         #1;
         if (c <= 3) begin
            check("lh_addr", dmem_addr, 32'h0000_2000);
            check("lh_be", {28'b0, dmem_be}, 32'hF);
         end
         if (stall_out) stalls++;
         if (valid_out) begin
            done = 1;
            check("lh_result", result_out, 32'hFFFF_8001);
            check("lh_rd", {27'b0, rd_out}, 32'd12);
         end
         step();
      end
      check("lh_done", {31'b0, done}, 32'd1);
      check("lh_stalls", stalls, 32'd5);
      quiet();

      // SW held from registered copy while inputs wander
      op(0, 1, 3'b010, 32'h0000_4000, 32'h1234_5678, 5'd0);
      #1;
      check("sw_stall0", {31'b0, stall_out}, 32'd1);
      step();
      alu_res_in = 32'h0; w_data_in = 32'h0; dmem_gnt = 1;
      #1;
      check("sw_addr", dmem_addr, 32'h0000_4000);
      check("sw_wdata", dmem_wdata, 32'h1234_5678);
      check("sw_valid", {31'b0, valid_out}, 32'd1);
      check("sw_stall", {31'b0, stall_out}, 32'd0);
      step();
      quiet();

      // Undefined funct3 loads as word
      op(1, 0, 3'b011, 32'h0000_6000, 32'h0, 5'd3);
      dmem_gnt = 1;
      step();
      dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
      #1;
      check("f3_011_result", result_out, 32'hCAFE_F00D);
      step();
      quiet();

      // Reset while waiting in RSP, then a stray rvalid
      op(1, 0, 3'b010, 32'h0000_5000, 32'h0, 5'd7);
      dmem_gnt = 1;
      step();
      dmem_gnt = 0;
      #1;
      check("rsp_stall", {31'b0, stall_out}, 32'd1);
      rst = 1;
      step();
      rst = 0;
      quiet();
      dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
      #1;
      check("rstrsp_valid", {31'b0, valid_out}, 32'd0);
      check("rstrsp_stall", {31'b0, stall_out}, 32'd0);
      check("rstrsp_result", result_out, 32'h0);
      check("rstrsp_rd", {27'b0, rd_out}, 32'd0);
      step();
      check("rstrsp_valid2", {31'b0, valid_out}, 32'd0);
      quiet();

      // Misaligned word load
      op(1, 0, 3'b010, 32'h0000_3002, 32'h0, 5'd4);
      dmem_gnt = 1;
      #1;
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_req", {31'b0, dmem_req}, 32'd0);
      check("mis_valid", {31'b0, valid_out}, 32'd1);
      check("mis_flag", {31'b0, misaligned_out}, 32'd1);
      check("mis_result", result_out, 32'h0000_3002);
      step();
`else
      check("mis_addr", dmem_addr, 32'h0000_3000);
      check("mis_be", {28'b0, dmem_be}, 32'hF);
      check("mis_flag", {31'b0, misaligned_out}, 32'd0);
      step();
      dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h0BAD_F00D;
      #1;
      check("mis_result", result_out, 32'h0BAD_F00D);
      step();
`endif
      quiet();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
